// File: rtl/command_line_ctrl.sv
// Keystroke-driven command line editor with valid/ready command issue.
// Ports: clk, reset(async low), clear, key_ascii/key_valid in; cmd_out,
// cmd_len, cmd_valid/cmd_ready, busy, overflow, dropped.
// Option: CMD_UPCASE_EN folds lowercase letters to uppercase when stored.
module command_line_ctrl #(
  parameter int CMD_CHARS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [7:0]             key_ascii,
  input  logic                   key_valid,
  output logic [8*CMD_CHARS-1:0] cmd_out,
  output logic [2:0]             cmd_len,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   busy,
  output logic                   overflow,
  output logic                   dropped
);

  localparam int W = 8 * CMD_CHARS;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_EDIT,
    S_ISSUE
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   buf_n;
  logic [2:0]     len_n;
  logic           ovf_n;
  logic           drop_n;
  logic           is_prn;
  logic           is_bs;
  logic           is_ent;
  logic [7:0]     key_st;

  assign is_prn = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign is_bs  = (key_ascii == 8'h08);
  assign is_ent = (key_ascii == 8'h0D);

`ifdef CMD_UPCASE_EN
  assign key_st = ((key_ascii >= 8'h61) && (key_ascii <= 8'h7A))
                ? key_ascii - 8'h20 : key_ascii;
`else
  assign key_st = key_ascii;
`endif

  always_comb begin
    state_n = state;
    buf_n   = cmd_out;
    len_n   = cmd_len;
    ovf_n   = overflow;
    drop_n  = dropped;
    if (clear) begin
      state_n = S_EMPTY;
      buf_n   = '0;
      len_n   = '0;
      ovf_n   = 1'b0;
      drop_n  = 1'b0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (key_valid && is_prn) begin
            buf_n[W-1 -: 8] = key_st;
            len_n   = 3'd1;
            state_n = S_EDIT;
          end
        end
        S_EDIT: begin
          if (key_valid && is_prn) begin
            if (cmd_len < 3'(CMD_CHARS)) begin
              for (int i = 0; i < CMD_CHARS; i++) begin
                if (3'(i) == cmd_len)
                  buf_n[8*(CMD_CHARS-1-i) +: 8] = key_st;
              end
              len_n = cmd_len + 3'd1;
            end else begin
              ovf_n = 1'b1;
            end
          end else if (key_valid && is_bs) begin
            for (int i = 0; i < CMD_CHARS; i++) begin
              if (3'(i + 1) == cmd_len)
                buf_n[8*(CMD_CHARS-1-i) +: 8] = 8'h00;
            end
            len_n = cmd_len - 3'd1;
            if (cmd_len == 3'd1)
              state_n = S_EMPTY;
          end else if (key_valid && is_ent) begin
            state_n = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Buffer is frozen; any keystroke here is lost.
          if (key_valid)
            drop_n = 1'b1;
          if (cmd_ready) begin
            buf_n   = '0;
            len_n   = '0;
            state_n = S_EMPTY;
          end
        end
        default: begin
          state_n = S_EMPTY;
          buf_n   = '0;
          len_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EMPTY;
      cmd_out   <= '0;
      cmd_len   <= '0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_out   <= buf_n;
      cmd_len   <= len_n;
      cmd_valid <= (state_n == S_ISSUE);
      busy      <= (state_n == S_ISSUE);
      overflow  <= ovf_n;
      dropped   <= drop_n;
    end
  end

endmodule

// File: tb/tb_command_line_ctrl.sv
// Self-checking bench for command_line_ctrl.
// Queue-based reference model plus directed literal checks.
module tb_command_line_ctrl;

  localparam int N = 5;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic         key_valid = 1'b0;
  logic [W-1:0] cmd_out;
  logic [2:0]   cmd_len;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic         busy;
  logic         overflow;
  logic         dropped;

  int n_chk = 0;
  int n_err = 0;

  command_line_ctrl #(.CMD_CHARS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .key_ascii (key_ascii),
    .key_valid (key_valid),
    .cmd_out   (cmd_out),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  // Reference model state
  byte unsigned q[$];
  bit m_issue, m_ovf, m_drop;

  function automatic byte unsigned fold(input byte unsigned c);
`ifdef CMD_UPCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
    return c;
  endfunction

  function automatic logic [W-1:0] exp_out();
    logic [W-1:0] e = '0;
    for (int i = 0; i < q.size(); i++)
      e[W-1-8*i -: 8] = q[i];
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_issue = 0; m_ovf = 0; m_drop = 0;
    end else if (clear) begin
      q.delete();
      m_issue = 0; m_ovf = 0; m_drop = 0;
    end else if (m_issue) begin
      if (key_valid) m_drop = 1;
      if (cmd_ready) begin
        q.delete();
        m_issue = 0;
      end
    end else if (key_valid) begin
      if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
        if (q.size() < N) q.push_back(fold(key_ascii));
        else m_ovf = 1;
      end else if (key_ascii == 8'h08 && q.size() > 0) begin
        void'(q.pop_back());
      end else if (key_ascii == 8'h0D && q.size() > 0) begin
        m_issue = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("m_cmd_out", cmd_out, exp_out());
      chk("m_cmd_len", W'(cmd_len), W'(q.size()));
      chk("m_valid", W'(cmd_valid), W'(m_issue));
      chk("m_busy", W'(busy), W'(m_issue));
      chk("m_ovf", W'(overflow), W'(m_ovf));
      chk("m_drop", W'(dropped), W'(m_drop));
    end
  end

  task automatic key(input logic [7:0] c);
    key_ascii = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) key(s[i]);
  endtask

  initial begin
    idle(3);
    chk("rst_out", cmd_out, '0);
    chk("rst_len", W'(cmd_len), '0);
    chk("rst_flags", W'({cmd_valid, busy, overflow, dropped}), '0);
    reset = 1'b1;
    idle(1);

    // RED with ready held high: valid exactly one cycle
    cmd_ready = 1'b1;
    type_str("RED");
    chk("red_out", cmd_out, 40'h5245440000);
    chk("red_len", W'(cmd_len), 3);
    key(8'h0D);
    chk("red_valid", W'(cmd_valid), 1);
    chk("red_busy", W'(busy), 1);
    idle(1);
    chk("red_valid_drop", W'(cmd_valid), 0);
    chk("red_len0", W'(cmd_len), 0);

    // Overflow then backspace
    cmd_ready = 1'b0;
    type_str("ABCDEF");
    chk("ovf_out", cmd_out, 40'h4142434445);
    chk("ovf_len", W'(cmd_len), 5);
    chk("ovf_flag", W'(overflow), 1);
    key(8'h08);
    chk("bs_out", cmd_out, 40'h4142434400);
    chk("bs_len", W'(cmd_len), 4);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clr_ovf", W'(overflow), 0);

    // Ignored keys on an empty buffer
    key(8'h0D);
    key(8'h08);
    key(8'h1B);
    chk("empty_out", cmd_out, '0);
    chk("empty_len", W'(cmd_len), 0);
    chk("empty_valid", W'(cmd_valid), 0);

    // Held issue with typing in between
    key("G");
    key(8'h0D);
    for (int i = 0; i < 10; i++) key("X");
    chk("hold_out", cmd_out, 40'h4700000000);
    chk("hold_drop", W'(dropped), 1);
    chk("hold_valid", W'(cmd_valid), 1);
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    chk("acc_valid", W'(cmd_valid), 0);
    chk("acc_len", W'(cmd_len), 0);
    chk("acc_drop_sticky", W'(dropped), 1);

    // Clear beats a key in ISSUE
    key("Z");
    key(8'h0D);
    clear = 1'b1;
    key("Q");
    clear = 1'b0;
    chk("clrq_out", cmd_out, '0);
    chk("clrq_flags", W'({cmd_valid, cmd_len, overflow, dropped}), '0);

    // Case folding option
    type_str("on");
    key(8'h0D);
`ifdef CMD_UPCASE_EN
    chk("case_out", cmd_out, 40'h4F4E000000);
`else
    chk("case_out", cmd_out, 40'h6F6E000000);
`endif
    cmd_ready = 1'b1;
    idle(1);
    chk("case_acc", W'(cmd_valid), 0);

    // Key in the same cycle as the transfer is dropped
    key("H");
    key(8'h0D);
    key("J");
    chk("xfer_len", W'(cmd_len), 0);
    chk("xfer_drop", W'(dropped), 1);
    cmd_ready = 1'b0;

    // Asynchronous reset mid-edit
    type_str("ab");
    #2 reset = 1'b0;
    #1;
    chk("arst_out", cmd_out, '0);
    chk("arst_all", W'({cmd_len, cmd_valid, busy, overflow, dropped}), '0);
    @(negedge clk);
    reset = 1'b1;
    type_str("K");
    key(8'h0D);
    chk("post_rst", cmd_out, 40'h4B00000000);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
